// File: rtl/group_seq_pkg.sv
// Shared types and constants for the grouped update-order sequencer and the LUT level above it.
package group_seq_pkg;

    typedef logic [2:0] group_code_t;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN,
        DONE
    } seq_state_t;

    localparam int unsigned NUM_GROUPS_DEF = 4;
    localparam group_code_t INIT_CODE      = 3'd4;

    // Colour groups run 0..num_groups-1 and then wrap back to 0.
    function automatic group_code_t next_group(group_code_t g, int unsigned num_groups);
        if ({29'd0, g} + 32'd1 >= num_groups) begin
            return '0;
        end
        return g + 3'd1;
    endfunction

endpackage

// File: rtl/group_update_sequencer_hold_timer.sv
// Loadable down-counter that holds each group for its settle time; zero marks the last hold cycle.
module hold_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         enable,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/group_update_sequencer.sv
// Steps the colour-group code for the p-bit update LUT and counts sweeps.
// Define GROUP_SEQ_INIT_EN to prefix every run with one clamp/init group (INIT_CODE).
module group_update_sequencer #(
    parameter int unsigned               NUM_GROUPS = group_seq_pkg::NUM_GROUPS_DEF,
    parameter group_seq_pkg::group_code_t INIT_CODE = group_seq_pkg::INIT_CODE,
    parameter int unsigned               HOLD_W     = 8,
    parameter int unsigned               SWEEP_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [HOLD_W-1:0]  hold_cycles,
    input  logic [SWEEP_W-1:0] num_sweeps,
    output logic [0:2]         group_EN,
    output logic               group_valid,
    output logic               sweep_done,
    output logic [SWEEP_W-1:0] sweep_count,
    output logic               busy,
    output logic               done
);

    import group_seq_pkg::*;

`ifdef GROUP_SEQ_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    localparam group_code_t START_CODE = INIT_EN ? INIT_CODE : group_code_t'(0);
    localparam group_code_t LAST_CODE  = group_code_t'(NUM_GROUPS - 1);

    seq_state_t         state;
    seq_state_t         state_next;
    group_code_t        group_q;
    logic [HOLD_W-1:0]  reload_q;
    logic [HOLD_W-1:0]  load_value;
    logic [SWEEP_W-1:0] target_q;
    logic [SWEEP_W-1:0] count_inc;
    logic               stop_pending;
    logic               stop_now;
    logic               hold_zero;
    logic               timer_load;
    logic               accept_start;
    logic               group_end;
    logic               sweep_end;
    logic               run_finish;

    assign accept_start = (state == IDLE) && start;
    assign busy         = (state == INIT) || (state == RUN);
    assign group_end    = busy && hold_zero;
    assign sweep_end    = (state == RUN) && hold_zero && (group_q == LAST_CODE);
    assign count_inc    = (sweep_count == '1) ? sweep_count : sweep_count + 1'b1;
    assign run_finish   = sweep_end && (target_q != '0) && (count_inc == target_q);
    assign stop_now     = stop_pending || stop;

    // A hold of zero behaves as one cycle, so the counter reload is max(hold,1)-1.
    assign load_value = accept_start ? ((hold_cycles == '0) ? '0 : hold_cycles - 1'b1) : reload_q;
    assign timer_load = accept_start || (group_end && (state_next != DONE));

    hold_timer #(
        .W(HOLD_W)
    ) u_hold_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .enable (busy),
        .value  (load_value),
        .zero   (hold_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = INIT_EN ? INIT : RUN;
                end
            end
            INIT: begin
                if (hold_zero) begin
                    state_next = stop_now ? DONE : RUN;
                end
            end
            RUN: begin
                if (hold_zero && (stop_now || run_finish)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Run settings are captured once per run so mid-run input changes cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            group_q      <= '0;
            reload_q     <= '0;
            target_q     <= '0;
            sweep_count  <= '0;
            stop_pending <= 1'b0;
        end else if (accept_start) begin
            group_q      <= START_CODE;
            reload_q     <= load_value;
            target_q     <= num_sweeps;
            sweep_count  <= '0;
            stop_pending <= 1'b0;
        end else begin
            if (busy && stop) begin
                stop_pending <= 1'b1;
            end
            if (sweep_end) begin
                sweep_count <= count_inc;
            end
            if (group_end && (state_next == RUN)) begin
                group_q <= (state == RUN) ? next_group(group_q, NUM_GROUPS) : group_code_t'(0);
            end
        end
    end

    assign group_EN    = group_q;
    assign group_valid = busy;
    assign sweep_done  = sweep_end;
    assign done        = (state == DONE);

endmodule

// File: tb/tb_group_update_sequencer.sv
// Self-checking bench for group_update_sequencer: an arithmetic run model checked every cycle
// plus hand-computed spot checks. Works with or without GROUP_SEQ_INIT_EN.
module tb_group_update_sequencer;

    localparam int NG  = 4;
    localparam int BIG = 1 << 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [7:0]  hold_cycles = 8'd0;
    logic [15:0] num_sweeps = 16'd0;
    logic [0:2]  group_EN;
    logic        group_valid;
    logic        sweep_done;
    logic [15:0] sweep_count;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model of one run: cycle k=1 is the first cycle after the start edge.
    bit have_run = 1'b0;
    bit cmp_en = 1'b0;
    int t0 = 0;
    int m_h = 1;
    int m_i = 0;
    int m_s = 0;
    int m_stop = BIG;
    int prev_g = 0;
    int prev_c = 0;

    typedef struct {
        int g;
        int valid;
        int sd;
        int cnt;
        int busy;
        int done;
    } exp_t;

    group_update_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .hold_cycles (hold_cycles),
        .num_sweeps  (num_sweeps),
        .group_EN    (group_EN),
        .group_valid (group_valid),
        .sweep_done  (sweep_done),
        .sweep_count (sweep_count),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Last busy cycle of the run: sweep target reached, or the end of the group a stop landed in.
    function automatic int end_cycle();
        int hn;
        int a;
        hn = m_h * NG;
        a = (m_s == 0) ? BIG : m_i + m_s * hn;
        if (m_stop <= a) begin
            if (m_stop <= m_i) a = m_i;
            else a = m_i + ((m_stop - m_i + m_h - 1) / m_h) * m_h;
        end
        return a;
    endfunction

    function automatic int group_at(int k);
        return (k <= m_i) ? 4 : ((k - m_i - 1) / m_h) % NG;
    endfunction

    function automatic int count_at(int k);
        return (k - 1 >= m_i) ? (k - 1 - m_i) / (m_h * NG) : 0;
    endfunction

    function automatic exp_t expect_at(int k);
        exp_t e;
        int a;
        e = '{prev_g, 0, 0, prev_c, 0, 0};
        if (!have_run) begin
            e = '{0, 0, 0, 0, 0, 0};
            return e;
        end
        if (k < 1) return e;
        a = end_cycle();
        if (k <= a) begin
            e.g     = group_at(k);
            e.valid = 1;
            e.busy  = 1;
            e.cnt   = count_at(k);
            e.sd    = (k > m_i && ((k - m_i) % (m_h * NG)) == 0) ? 1 : 0;
        end else begin
            e.g    = group_at(a);
            e.cnt  = count_at(a + 1);
            e.done = (k == a + 1) ? 1 : 0;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d, k=%0d)", name, act, exp, cyc, cyc - t0);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (cmp_en) begin
            e = expect_at(cyc - t0);
            checkOutput("group_EN", int'(group_EN), e.g);
            checkOutput("group_valid", int'(group_valid), e.valid);
            checkOutput("sweep_done", int'(sweep_done), e.sd);
            checkOutput("sweep_count", int'(sweep_count), e.cnt);
            checkOutput("busy", int'(busy), e.busy);
            checkOutput("done", int'(done), e.done);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int k);
        while (cyc - t0 < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulses start for one cycle and arms the model; returns in cycle k=1.
    task automatic applyStimulus(input int h, input int s);
        exp_t e;
        e = expect_at(cyc - t0);
        prev_g = e.g;
        prev_c = e.cnt;
        hold_cycles = 8'(h);
        num_sweeps  = 16'(s);
        start  = 1'b1;
        t0     = cyc;
        m_h    = (h == 0) ? 1 : h;
`ifdef GROUP_SEQ_INIT_EN
        m_i    = m_h;
`else
        m_i    = 0;
`endif
        m_s    = s;
        m_stop = BIG;
        have_run = 1'b1;
        wait_cycles(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        int k;
        k = cyc - t0;
        stop = 1'b1;
        if (have_run && m_stop == BIG && k >= 1 && k <= end_cycle()) m_stop = k;
        wait_cycles(1);
        stop = 1'b0;
    endtask

    initial begin
        int off;
        cmp_en = 1'b1;
        wait_cycles(2);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_group", int'(group_EN), 0);
        checkOutput("reset_count", int'(sweep_count), 0);
        rst_n = 1'b1;
        wait_cycles(2);

        // hold 3, two sweeps
        applyStimulus(3, 2);
        off = m_i;
        wait_to(off + 12);
        checkOutput("t1_sweep_done_12", int'(sweep_done), 1);
        checkOutput("t1_group_12", int'(group_EN), 3);
        wait_to(off + 24);
        checkOutput("t1_sweep_done_24", int'(sweep_done), 1);
        wait_to(off + 25);
        checkOutput("t1_done", int'(done), 1);
        checkOutput("t1_count", int'(sweep_count), 2);
        wait_to(off + 27);
        checkOutput("t1_idle_valid", int'(group_valid), 0);

        // hold 0 behaves as 1, one sweep
        applyStimulus(0, 1);
        wait_to(off / 3 + 4);
        checkOutput("t2_group3", int'(group_EN), 3);
        checkOutput("t2_sweep_done", int'(sweep_done), 1);
        wait_to(off / 3 + 5);
        checkOutput("t2_done", int'(done), 1);
        checkOutput("t2_count", int'(sweep_count), 1);
        wait_cycles(2);

        // free-run, stop in group 1 of sweep 5
        applyStimulus(2, 0);
        off = m_i;
        wait_to(off + 35);
        checkOutput("t3_group_at_stop", int'(group_EN), 1);
        pulse_stop();
        checkOutput("t3_group_finishes", int'(group_EN), 1);
        wait_to(off + 37);
        checkOutput("t3_done", int'(done), 1);
        checkOutput("t3_count", int'(sweep_count), 4);
        wait_cycles(2);

`ifdef GROUP_SEQ_INIT_EN
        // init group held four cycles before group 0
        applyStimulus(4, 1);
        checkOutput("t4_init_k1", int'(group_EN), 4);
        checkOutput("t4_init_valid", int'(group_valid), 1);
        wait_to(4);
        checkOutput("t4_init_k4", int'(group_EN), 4);
        wait_to(5);
        checkOutput("t4_group0", int'(group_EN), 0);
        wait_to(23);
`endif

        // start while busy and hold change mid-run are ignored
        applyStimulus(2, 1);
        off = m_i;
        wait_to(off + 3);
        hold_cycles = 8'd9;
        start = 1'b1;
        wait_cycles(1);
        start = 1'b0;
        wait_to(off + 5);
        checkOutput("t5_group2", int'(group_EN), 2);
        wait_to(off + 8);
        checkOutput("t5_group3", int'(group_EN), 3);
        wait_to(off + 9);
        checkOutput("t5_done", int'(done), 1);
        wait_cycles(2);

        // asynchronous reset during group 2 of sweep 2
        applyStimulus(3, 0);
        off = m_i;
        wait_to(off + 20);
        checkOutput("t6_group2", int'(group_EN), 2);
        checkOutput("t6_count1", int'(sweep_count), 1);
        #2;
        rst_n = 1'b0;
        have_run = 1'b0;
        #1;
        checkOutput("t6_rst_group", int'(group_EN), 0);
        checkOutput("t6_rst_valid", int'(group_valid), 0);
        checkOutput("t6_rst_count", int'(sweep_count), 0);
        checkOutput("t6_rst_busy", int'(busy), 0);
        wait_cycles(1);
        rst_n = 1'b1;
        wait_cycles(2);
        pulse_stop();
        wait_cycles(2);
        checkOutput("t6_idle_stop_busy", int'(busy), 0);
        applyStimulus(1, 1);
        checkOutput("t6_restart_busy", int'(busy), 1);
        checkOutput("t6_restart_count", int'(sweep_count), 0);
        wait_to(m_i + 1);
        checkOutput("t6_restart_group", int'(group_EN), 0);
        wait_to(m_i + 7);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
